// File: rtl/programmable_blinker_pkg.sv
// Shared definitions for the programmable blinker.
//   blink_state_e : two-state FSM encoding (BLINK_OFF / BLINK_ON)
//   PERIOD_RESET  : one-hot reset period for the default 4-bit register (P = 4)
//   period_reset  : reset period for any register width (one-hot bit width/2)
package programmable_blinker_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic {
    BLINK_OFF = 1'b0,
    BLINK_ON  = 1'b1
  } blink_state_e;

  localparam logic [DEFAULT_WIDTH-1:0] PERIOD_RESET = 4'b0100;

  // Generalises PERIOD_RESET to other widths; returns the one-hot value LSB-aligned.
  function automatic logic [31:0] period_reset(int unsigned width);
    if (width == DEFAULT_WIDTH) begin
      return 32'(PERIOD_RESET);
    end
    return 32'd1 << (width / 2);
  endfunction

endpackage

// File: rtl/dffr.sv
// Team flop: D flip-flop with synchronous active-high reset.
//   clk : clock
//   r   : synchronous reset, active high, loads ResetVal
//   d   : next value
//   q   : registered value
module dffr #(
  parameter int unsigned       Width    = 1,
  parameter logic [Width-1:0]  ResetVal = '0
) (
  input  logic             clk,
  input  logic             r,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  always_ff @(posedge clk) begin
    if (r) begin
      q <= ResetVal;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/programmable_blinker_period_shifter.sv
// Saturating one-hot period register.
//   clk    : clock
//   rst    : synchronous reset, active low, loads the reset period
//   faster : shift right (halve P), saturating at bit 0
//   slower : shift left (double P), saturating at bit WIDTH-1
//   period : current one-hot period
module programmable_blinker_period_shifter
  import programmable_blinker_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             faster,
  input  logic             slower,
  output logic [WIDTH-1:0] period
);

  localparam logic [WIDTH-1:0] ResetVal = WIDTH'(period_reset(WIDTH));

  logic [WIDTH-1:0] period_d;

  // Saturation holds the end bit, so the register can never leave one-hot.
  always_comb begin
    period_d = period;
    unique case ({faster, slower})
      2'b10:   if (!period[0])       period_d = period >> 1;
      2'b01:   if (!period[WIDTH-1]) period_d = period << 1;
      default: period_d = period;
    endcase
  end

  dffr #(
    .Width    (WIDTH),
    .ResetVal (ResetVal)
  ) u_period_q (
    .clk (clk),
    .r   (~rst),
    .d   (period_d),
    .q   (period)
  );

endmodule

// File: rtl/programmable_blinker.sv
// 50% duty-cycle LED blinker driven by an external beat tick.
//   clk    : clock
//   rst    : synchronous reset, active low
//   beat   : one-cycle time-base tick; each high cycle counts as one beat
//   faster : one-cycle request to halve the phase length P
//   slower : one-cycle request to double the phase length P
//   led    : registered blinker output, high while the FSM is ON
//   period : registered one-hot P (beats per phase)
module programmable_blinker
  import programmable_blinker_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             beat,
  input  logic             faster,
  input  logic             slower,
  output logic             led,
  output logic [WIDTH-1:0] period
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             state_raw;
  blink_state_e     state_q, state_d;
  logic             term;

  programmable_blinker_period_shifter #(
    .WIDTH (WIDTH)
  ) u_period_shifter (
    .clk    (clk),
    .rst    (rst),
    .faster (faster),
    .slower (slower),
    .period (period)
  );

  // A one-hot period read as an unsigned number is P itself. The >= (not ==) ends the
  // phase on the next beat when P has shrunk below the count already reached.
  assign term = beat && (cnt_q >= (period - WIDTH'(1)));

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if (term) begin
      cnt_d   = '0;
      state_d = (state_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
    end else if (beat) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  dffr #(
    .Width    (WIDTH),
    .ResetVal ('0)
  ) u_cnt_q (
    .clk (clk),
    .r   (~rst),
    .d   (cnt_d),
    .q   (cnt_q)
  );

  dffr #(
    .Width    (1),
    .ResetVal (BLINK_OFF)
  ) u_state_q (
    .clk (clk),
    .r   (~rst),
    .d   (state_d),
    .q   (state_raw)
  );

  assign state_q = blink_state_e'(state_raw);
  assign led     = (state_q == BLINK_ON);

endmodule

// File: tb/tb_programmable_blinker.sv
// Self-checking bench: integer-arithmetic reference model compared every cycle,
// directed scenarios with literal expectations, then randomized stimulus.
module tb_programmable_blinker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       beat = 1'b0;
  logic       faster = 1'b0;
  logic       slower = 1'b0;
  logic       led;
  logic [3:0] period;

  int unsigned errors = 0;
  int unsigned checks = 0;
  bit          cmp_en = 1'b0;

  // Reference model: P as a plain integer, beats elapsed in the current phase.
  int unsigned m_p   = 4;
  int unsigned m_cnt = 0;
  bit          m_led = 1'b0;

  always #5 clk = ~clk;

  programmable_blinker #(
    .WIDTH (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .beat   (beat),
    .faster (faster),
    .slower (slower),
    .led    (led),
    .period (period)
  );

  always @(posedge clk) begin
    if (!rst) begin
      m_p   <= 4;
      m_cnt <= 0;
      m_led <= 1'b0;
    end else begin
      if (beat) begin
        if (m_cnt + 1 >= m_p) begin
          m_led <= !m_led;
          m_cnt <= 0;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
      if (faster && !slower) m_p <= (m_p > 1) ? m_p / 2 : 1;
      else if (slower && !faster) m_p <= (m_p < 8) ? m_p * 2 : 8;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_led", 32'(led), 32'(m_led));
      chk("model_period", 32'(period), 32'(m_p));
    end
  end

  // Drive inputs just after a falling edge; return at the next falling edge.
  task automatic step(input bit b, input bit f, input bit s, input bit r);
    beat   = b;
    faster = f;
    slower = s;
    rst    = r;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // One beat on the 32-clock grid, optionally with a period request on the beat edge.
  task automatic do_beat(input bit f, input bit s);
    idle(31);
    step(1'b1, f, s, 1'b1);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    @(negedge clk);

    // Reset and default blink.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      cmp_en = 1'b1;
      chk("reset_led", 32'(led), 32'd0);
      chk("reset_period", 32'(period), 32'h4);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      do_beat(1'b0, 1'b0);
      chk("first_rise", 32'(led), (i == 4) ? 32'd1 : 32'd0);
    end
    for (int i = 1; i <= 4; i++) begin
      do_beat(1'b0, 1'b0);
      chk("first_fall", 32'(led), (i == 4) ? 32'd0 : 32'd1);
    end

    // Faster to saturation, then toggle on every beat.
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("faster_1", 32'(period), 32'h2);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("faster_2", 32'(period), 32'h1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("faster_sat", 32'(period), 32'h1);
    do_beat(1'b0, 1'b0);
    chk("p1_toggle_a", 32'(led), 32'd1);
    do_beat(1'b0, 1'b0);
    chk("p1_toggle_b", 32'(led), 32'd0);

    // Slower to saturation from reset; phases of 8 beats.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1);
      chk("slower_sat", 32'(period), 32'h8);
    end
    for (int i = 1; i <= 8; i++) begin
      do_beat(1'b0, 1'b0);
      chk("p8_phase", 32'(led), (i == 8) ? 32'd1 : 32'd0);
    end

    // Shrink mid-phase: P=8, five beats in, then P=2.
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) do_beat(1'b0, 1'b0);
    chk("shrink_pre", 32'(led), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("shrink_period", 32'(period), 32'h2);
    do_beat(1'b0, 1'b0);
    chk("shrink_toggle", 32'(led), 32'd1);
    do_beat(1'b0, 1'b0);
    chk("shrink_cnt0_hold", 32'(led), 32'd1);
    do_beat(1'b0, 1'b0);
    chk("shrink_next", 32'(led), 32'd0);

    // Simultaneous faster+slower hold; slower on a terminal beat.
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("both_hold", 32'(period), 32'h2);
    do_reset();
    for (int i = 0; i < 3; i++) do_beat(1'b0, 1'b0);
    do_beat(1'b0, 1'b1);
    chk("term_slower_led", 32'(led), 32'd1);
    chk("term_slower_period", 32'(period), 32'h8);
    for (int i = 1; i <= 8; i++) begin
      do_beat(1'b0, 1'b0);
      chk("term_slower_phase", 32'(led), (i == 8) ? 32'd0 : 32'd1);
    end

    // Reset mid-phase with led high and two beats counted; beats ignored in reset.
    do_reset();
    for (int i = 0; i < 6; i++) do_beat(1'b0, 1'b0);
    chk("mid_pre", 32'(led), 32'd1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("mid_reset_led", 32'(led), 32'd0);
    chk("mid_reset_period", 32'(period), 32'h4);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("mid_reset_hold", 32'(period), 32'h4);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      do_beat(1'b0, 1'b0);
      chk("mid_after", 32'(led), (i == 4) ? 32'd1 : 32'd0);
    end

    // Randomized: irregular and back-to-back beats, requests, occasional reset.
    for (int i = 0; i < 6000; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 299) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
